// File: rtl/cmp_pkg.sv
// Shared compare codes, FSM state encoding and cascade normalisation.
package cmp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cmpState_t;

    // Anything other than a clean greater/less code is treated as equal.
    function automatic logic [2:0] cmp_norm(input logic [2:0] code);
        return ((code == CMP_GT) || (code == CMP_LT)) ? code : CMP_EQ;
    endfunction

endpackage

// File: rtl/compare_nibble.sv
// One 4-bit magnitude compare stage with cascade input.
module compare_nibble
    import cmp_pkg::*;
(
    input  logic [3:0] iA,
    input  logic [3:0] iB,
    input  logic [2:0] iCasc,
    output logic [2:0] oRes_c
);

    // A differing nibble overrides the cascade; equal nibbles pass it through.
    always_comb begin
        oRes_c = iCasc;
        if (iA > iB) begin
            oRes_c = CMP_GT;
        end else if (iA < iB) begin
            oRes_c = CMP_LT;
        end
    end

endmodule

// File: rtl/compare_seq.sv
// Multi-cycle wide magnitude comparator, one nibble per clock, LSB nibble first.
module compare_seq
    import cmp_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iStart,
    input  logic [4*NIBBLES-1:0] iData_a,
    input  logic [4*NIBBLES-1:0] iData_b,
    input  logic [2:0]           iData,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2:0]           oData
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    cmpState_t        stateQ, stateD;
    logic [W-1:0]     opAQ, opAD;
    logic [W-1:0]     opBQ, opBD;
    logic [2:0]       cascQ, cascD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             busyQ, busyD;
    logic             doneQ, doneD;
    logic [2:0]       dataQ, dataD;

    logic [3:0]       nibA, nibB;
    logic [2:0]       stageRes;

    // Select the nibble pair addressed by the counter.
    always_comb begin
        nibA = 4'(opAQ >> {cntQ, 2'b00});
        nibB = 4'(opBQ >> {cntQ, 2'b00});
    end

    compare_nibble uStage (
        .iA     (nibA),
        .iB     (nibB),
        .iCasc  (cascQ),
        .oRes_c (stageRes)
    );

    // State and datapath registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            stateQ <= IDLE;
            opAQ   <= '0;
            opBQ   <= '0;
            cascQ  <= '0;
            cntQ   <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            dataQ  <= CMP_EQ;
        end else begin
            stateQ <= stateD;
            opAQ   <= opAD;
            opBQ   <= opBD;
            cascQ  <= cascD;
            cntQ   <= cntD;
            busyQ  <= busyD;
            doneQ  <= doneD;
            dataQ  <= dataD;
        end
    end

    // Next-state and next-output logic; the result only moves on completion.
    always_comb begin
        stateD = stateQ;
        opAD   = opAQ;
        opBD   = opBQ;
        cascD  = cascQ;
        cntD   = cntQ;
        busyD  = busyQ;
        doneD  = 1'b0;
        dataD  = dataQ;

        case (stateQ)
            IDLE: begin
                busyD = 1'b0;
                if (iStart) begin
                    opAD   = iData_a;
                    opBD   = iData_b;
                    cascD  = cmp_norm(iData);
                    cntD   = '0;
                    busyD  = 1'b1;
                    stateD = RUN;
                end
            end
            RUN: begin
                cascD = stageRes;
                cntD  = cntQ + CNT_W'(1);
                if (cntQ == LAST) begin
                    cntD   = '0;
                    dataD  = stageRes;
                    doneD  = 1'b1;
                    busyD  = 1'b0;
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
                busyD  = 1'b0;
            end
        endcase
    end

    assign oBusy = busyQ;
    assign oDone = doneQ;
    assign oData = dataQ;

endmodule
